// File: rtl/mux_rr_n.sv
// N-channel registered mux with fixed-select and round-robin arbitration.
// One output register; ack marks the channel word captured on the next edge.
module mux_rr_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] d,
  input  logic [NCH-1:0]       vld,
  input  logic [SELW-1:0]      s,
  input  logic                 mode,
  input  logic                 rdy,
  output logic [NCH-1:0]       ack,
  output logic [WIDTH-1:0]     y,
  output logic                 y_vld,
  output logic [SELW-1:0]      ch
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d, ptr_q, ptr_d;
  logic             y_vld_q, y_vld_d;

  logic             load_en, found;
  logic [SELW-1:0]  gidx;
  logic [NCH-1:0]   grant;
  logic [WIDTH-1:0] dsel;
  logic [2*NCH-1:0] vv2;
  logic [NCH-1:0]   rot;
  logic [SELW:0]    first, rr_sum;

  assign load_en = (!y_vld_q || rdy) && !rst;

  // Round-robin: rotate vld so ptr sits at bit 0, take lowest set bit, un-rotate.
  always_comb begin
    vv2    = {vld, vld} >> ptr_q;
    rot    = vv2[NCH-1:0];
    first  = '0;
    for (int i = NCH-1; i >= 0; i--)
      if (rot[i]) first = (SELW+1)'(i);
    rr_sum = {1'b0, ptr_q} + first;
    if (rr_sum >= NCH_W) rr_sum = rr_sum - NCH_W;
  end

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    if (!mode) begin
      // s beyond the last channel matches no k, so it grants nothing
      for (int k = 0; k < NCH; k++)
        if (s == SELW'(k) && vld[k]) begin
          found = 1'b1;
          gidx  = SELW'(k);
        end
    end else if (|vld) begin
      found = 1'b1;
      gidx  = rr_sum[SELW-1:0];
    end
  end

  always_comb begin
    grant = '0;
    dsel  = '0;
    for (int k = 0; k < NCH; k++)
      if (gidx == SELW'(k)) begin
        grant[k] = found;
        dsel     = d[k*WIDTH +: WIDTH];
      end
  end

  assign ack = load_en ? grant : '0;

  always_comb begin
    y_d     = y_q;
    ch_d    = ch_q;
    y_vld_d = y_vld_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (found) begin
        y_d     = dsel;
        ch_d    = gidx;
        y_vld_d = 1'b1;
        if (mode)
          ptr_d = ({1'b0, gidx} + 1'b1 == NCH_W) ? '0 : gidx + 1'b1;
      end else begin
        y_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      ch_q    <= '0;
      y_vld_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      y_vld_q <= y_vld_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign y_vld = y_vld_q;

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 Parameter WIDTH, default 8, data width of every channel and of y.
REQ-002 Parameter NCH, default 4, number of input channels; legal range 2..8.
REQ-003 Parameter SELW, default 2, width of s and ch; SHALL satisfy 2**SELW >= NCH.
REQ-004 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 d input NCH*WIDTH, channel data packed flat; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 vld input NCH, per-channel valid; bit k qualifies channel k.
REQ-007 s input SELW, channel select used in fixed mode.
REQ-008 mode input 1: 0 = fixed select, 1 = round-robin.
REQ-009 rdy input 1, downstream ready for y.
REQ-010 ack output NCH, one-hot combinational acceptance; bit k high = channel k word taken this cycle.
REQ-011 y output WIDTH, registered selected data.
REQ-012 y_vld output 1, registered; y is valid.
REQ-013 ch output SELW, registered index of the channel held in y.

Function
REQ-014 Output stage SHALL be a single register: load_en = (!y_vld | rdy) & !rst.
REQ-015 Fixed mode: grant channel s iff vld[s]=1 and s < NCH; s >= NCH grants nothing.
REQ-016 Round-robin mode: search vld from pointer ptr upward, wrapping NCH-1 -> 0; grant the first valid channel found.
REQ-017 ptr SHALL update to (granted+1) mod NCH only on an accepted transfer; unchanged otherwise and in fixed mode.
REQ-018 ack[k] = load_en & grant[k]; at most one ack bit high per cycle.
REQ-019 On accept: y <= d[k], ch <= k, y_vld <= 1 at the next rising edge (latency 1 cycle).
REQ-020 No grant and load_en: y_vld <= 0; y and ch hold their last values.
REQ-021 y_vld=1 and rdy=0: y, ch, y_vld hold; ack SHALL be all-zero (backpressure).
REQ-022 y_vld=1, rdy=1 and a grant in the same cycle: drain and reload in that cycle, y_vld stays 1 (full throughput, one word per cycle).
REQ-023 mode or s change takes effect on the next load decision; held output word not altered.
REQ-024 Changing vld or d of a channel not acked SHALL have no side effect on state.

Reset
REQ-025 rst=1 at a rising edge: y <= 0, ch <= 0, y_vld <= 0, ptr <= 0.
REQ-026 While rst=1, ack SHALL be all-zero regardless of vld, rdy, mode.
REQ-027 Reset mid-transfer SHALL discard the held word; first grant after release starts search from channel 0.

Verification
REQ-028 Fixed: d0..d3 = 8'h33,8'h43,8'hAD,8'hAF, vld=4'hF, mode=0, s=1, rdy=1 -> ack=4'b0010, next cycle y=8'h43, ch=1, y_vld=1; s=2 -> next y=8'hAD.
REQ-029 Round-robin: vld=4'hF, mode=1, rdy=1 from reset -> y sequence 33,43,AD,AF,33 on consecutive cycles, ch 0,1,2,3,0 (wrap).
REQ-030 Sparse RR: vld=4'b1010, mode=1, rdy=1 -> ch alternates 1,3,1,3; channels 0 and 2 never acked.
REQ-031 Backpressure: y_vld=1 with y=8'h43, rdy=0 for 3 cycles while d1 changes to 8'h55 -> y stays 8'h43, ack=0; rdy=1 -> next word loaded same cycle.
REQ-032 Reset mid-stream: RR running at ch=2, rst=1 for 1 cycle -> y=0, ch=0, y_vld=0; after release with vld=4'hF first grant is channel 0.
REQ-033 Fixed invalid: NCH=3, SELW=2, s=3 or vld[s]=0 -> ack=0, y_vld drops to 0 after rdy=1.
